execute_stage: RTL and testbench
================================

# execute_stage

Pipeline execute stage of the five-stage RV32I core, between decode and the memory stage. Holds the ID/EX pipeline register, applies hazard-unit forwarding, computes ALU result, branch/jump redirect and target, and supplies the memory stage's ALU result, store data, destination register and PC+4. Also runs an iterative 32-cycle MUL unit and requests a pipeline stall through `o_BusyE` while the multiply runs.

## Interface
- No parameters; XLEN fixed at 32.
- `i_Clk` in 1: clock, rising edge.
- `i_Reset` in 1: asynchronous, active-low reset.
- `i_RD1D`, `i_RD2D`, `i_PCD`, `i_ImmExtD`, `i_PCPlus4D` in 32 each: decode data.
- `i_Rs1D`, `i_Rs2D`, `i_RdD` in 5 each: register indices.
- `i_RegWriteD`, `i_MemWriteD`, `i_JumpD`, `i_BranchD`, `i_ALUSrcD`, `i_JalrD` in 1 each: control.
- `i_ResultSrcD` in 2, `i_ALUControlD` in 4, `i_Funct3D` in 3: control.
- `i_FlushE` in 1: clear the ID/EX register (bubble).
- `i_ForwardAE`, `i_ForwardBE` in 2: 00 register file, 01 `i_ResultW`, 10 `i_ALUResultM`.
- `i_ALUResultM`, `i_ResultW` in 32: forwarding sources.
- `o_Rs1E`, `o_Rs2E`, `o_RdE` out 5: to hazard unit. `o_RdE` also goes to the memory stage.
- `o_ResultSrcE` out 2: hazard unit (load-use) and memory stage.
- `o_PCSrcE` out 1: redirect fetch. `o_PCTargetE` out 32: redirect address.
- `o_BusyE` out 1: stall F/D/E and insert a bubble into M.
- `o_ALUResultE`, `o_WriteDataE`, `o_PCPlus4E` out 32: to the memory stage.
- `o_RegWriteE`, `o_MemWriteE` out 1: to the memory stage. Forced to 0 while `o_BusyE`=1.

## Operation
- ID/EX register update priority, per edge: reset clears it; else `i_FlushE` clears it; else if `o_BusyE`=1 it holds; else it loads the D inputs. A cleared register decodes as ADD with all write enables 0.
- Operand A = forward mux of RD1E. Forwarded B = forward mux of RD2E, and `o_WriteDataE` = forwarded B. SrcB = `i_ALUSrcD`-registered ? ImmExtE : forwarded B. Forward code 11 selects RD.
- ALU opcodes:
  - 0000 ADD
  - 0001 SUB
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 SLT (signed)
  - 0110 SLTU
  - 0111 SLL
  - 1000 SRL
  - 1001 SRA
  - 1010 MUL (low 32 bits, multi-cycle)
  - others produce 0.
- Shifts use SrcB[4:0]. Arithmetic wraps modulo 2^32.
- Branch condition from forwarded A and B by Funct3E: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU. Other codes are not taken.
- `o_PCSrcE` = JumpE | (BranchE & cond).
- `o_PCTargetE` = JalrE ? (ALU result & ~1) : PCE + ImmExtE.
- MUL FSM states:
  - IDLE: if the E register holds MUL, assert `o_BusyE` combinationally. Next edge latches A into the multiplicand, SrcB into the multiplier, product 0, count 0, and goes to BUSY.
  - BUSY: each edge, if multiplier[0] then product += multiplicand; multiplicand <<= 1; multiplier >>= 1; count++. When count reaches 31 (32nd add), go to DONE.
  - DONE: `o_BusyE`=0; `o_ALUResultE` = product; write enable passes through. Next edge returns to IDLE as the E register loads the next instruction.
- Flush or reset in any state aborts to IDLE and discards the product.

## Timing
- All outputs are combinational from the E register and FSM. Non-MUL latency is 1 cycle, D edge to E outputs.
- A MUL loaded at edge t: `o_BusyE`=1 for cycles t..t+32 (33 cycles). The result is valid in cycle t+33, and the E register releases at the end of t+33.
- Operands are frozen at the IDLE→BUSY edge. Later changes to forwarding sources do not affect the result.
- Reset values: E register all 0, FSM IDLE, therefore `o_BusyE`=0, `o_PCSrcE`=0, `o_RegWriteE`=0, `o_MemWriteE`=0, and all 32-bit outputs 0.

## Structure
- Shared package `riscv_pkg` holds:
  - `alu_op_e` enum (4-bit encodings above)
  - `fwd_sel_e` (2-bit)
  - branch Funct3 constants
  - `mul_state_e` {IDLE, BUSY, DONE}
- Sub-module `seq_multiplier`: FSM, shift-add datapath, 5-bit counter. Ports: start, flush, a, b, busy, done, product.

## Test plan
- Reset asserted mid-MUL (BUSY, count 10) → all outputs 0 and `o_BusyE`=0 immediately, without waiting for a clock edge.
- ADD x3 with RD1=5, RD2=7 and ForwardAE=10, `i_ALUResultM`=100 → `o_ALUResultE`=107.
- BLT with A=-1, B=1 → `o_PCSrcE`=1 and `o_PCTargetE`=PCE+ImmExtE. BLTU with the same operands → `o_PCSrcE`=0.
- MUL 0xFFFFFFFF × 3 → `o_BusyE` high for exactly 33 cycles, `o_RegWriteE`=0 throughout, then `o_ALUResultE`=0xFFFFFFFD for one cycle with `o_RegWriteE`=1.
- MUL with ForwardAE=01: change `i_ResultW` after the first busy cycle → the result uses the value captured at the start.
- `i_FlushE` asserted while busy → IDLE next cycle, `o_BusyE`=0, register cleared, no write enables.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types and helpers for the RV32I execute stage
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLTU = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001,
        ALU_MUL  = 4'b1010
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10,
        FWD_RD = 2'b11
    } fwd_sel_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mul_state_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc_plus4;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_write;
        logic            jump;
        logic            branch;
        logic            alu_src;
        logic            jalr;
        logic [1:0]      result_src;
        logic [3:0]      alu_ctrl;
        logic [2:0]      funct3;
    } id_ex_t;

    // Code 11 is unused by the hazard unit and falls back to the register value.
    function automatic logic [XLEN-1:0] fwd_mux(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] rf,
        input logic [XLEN-1:0] res_w,
        input logic [XLEN-1:0] alu_m
    );
        case (sel)
            FWD_W:   return res_w;
            FWD_M:   return alu_m;
            default: return rf;
        endcase
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - 32-cycle shift-add multiplier, low 32 bits of the product
module seq_multiplier
    import riscv_pkg::*;
(
    input  logic            i_Clk,
    input  logic            i_Reset,
    input  logic            i_start,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_product
);

    mul_state_e      r_state;
    mul_state_e      w_state_nxt;
    logic [XLEN-1:0] r_mcand;
    logic [XLEN-1:0] r_mplier;
    logic [XLEN-1:0] r_prod;
    logic [4:0]      r_count;

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            IDLE: begin
                o_busy = i_start;
                if (i_start) w_state_nxt = BUSY;
            end
            BUSY: begin
                o_busy = 1'b1;
                if (r_count == 5'd31) w_state_nxt = DONE;
            end
            DONE: begin
                o_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (i_flush) w_state_nxt = IDLE;
    end

    // Operands are captured on the IDLE->BUSY edge so later forwarding changes cannot leak in.
    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_prod  <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_mcand  <= i_a;
                        r_mplier <= i_b;
                        r_prod   <= '0;
                        r_count  <= '0;
                    end
                end
                BUSY: begin
                    if (r_mplier[0]) r_prod <= r_prod + r_mcand;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign o_product = r_prod;

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - RV32I execute stage: ID/EX register, forwarding, ALU, branch and MUL
module execute_stage
    import riscv_pkg::*;
(
    input  logic            i_Clk,
    input  logic            i_Reset,
    input  logic [XLEN-1:0] i_RD1D,
    input  logic [XLEN-1:0] i_RD2D,
    input  logic [XLEN-1:0] i_PCD,
    input  logic [XLEN-1:0] i_ImmExtD,
    input  logic [XLEN-1:0] i_PCPlus4D,
    input  logic [4:0]      i_Rs1D,
    input  logic [4:0]      i_Rs2D,
    input  logic [4:0]      i_RdD,
    input  logic            i_RegWriteD,
    input  logic            i_MemWriteD,
    input  logic            i_JumpD,
    input  logic            i_BranchD,
    input  logic            i_ALUSrcD,
    input  logic            i_JalrD,
    input  logic [1:0]      i_ResultSrcD,
    input  logic [3:0]      i_ALUControlD,
    input  logic [2:0]      i_Funct3D,
    input  logic            i_FlushE,
    input  logic [1:0]      i_ForwardAE,
    input  logic [1:0]      i_ForwardBE,
    input  logic [XLEN-1:0] i_ALUResultM,
    input  logic [XLEN-1:0] i_ResultW,
    output logic [4:0]      o_Rs1E,
    output logic [4:0]      o_Rs2E,
    output logic [4:0]      o_RdE,
    output logic [1:0]      o_ResultSrcE,
    output logic            o_PCSrcE,
    output logic [XLEN-1:0] o_PCTargetE,
    output logic            o_BusyE,
    output logic [XLEN-1:0] o_ALUResultE,
    output logic [XLEN-1:0] o_WriteDataE,
    output logic [XLEN-1:0] o_PCPlus4E,
    output logic            o_RegWriteE,
    output logic            o_MemWriteE
);

    id_ex_t          r_ex;
    logic            w_busy;
    logic            w_mul_done;
    logic            w_cond;
    logic [XLEN-1:0] w_src_a;
    logic [XLEN-1:0] w_fwd_b;
    logic [XLEN-1:0] w_src_b;
    logic [XLEN-1:0] w_alu;
    logic [XLEN-1:0] w_product;

    // A cleared register decodes as ADD with every write enable low, i.e. a bubble.
    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            r_ex <= '0;
        end else if (i_FlushE) begin
            r_ex <= '0;
        end else if (!w_busy) begin
            r_ex <= '{rd1: i_RD1D, rd2: i_RD2D, pc: i_PCD, imm: i_ImmExtD,
                      pc_plus4: i_PCPlus4D, rs1: i_Rs1D, rs2: i_Rs2D, rd: i_RdD,
                      reg_write: i_RegWriteD, mem_write: i_MemWriteD,
                      jump: i_JumpD, branch: i_BranchD, alu_src: i_ALUSrcD,
                      jalr: i_JalrD, result_src: i_ResultSrcD,
                      alu_ctrl: i_ALUControlD, funct3: i_Funct3D};
        end
    end

    assign w_src_a = fwd_mux(i_ForwardAE, r_ex.rd1, i_ResultW, i_ALUResultM);
    assign w_fwd_b = fwd_mux(i_ForwardBE, r_ex.rd2, i_ResultW, i_ALUResultM);
    assign w_src_b = r_ex.alu_src ? r_ex.imm : w_fwd_b;

    seq_multiplier u_mul (
        .i_Clk     (i_Clk),
        .i_Reset   (i_Reset),
        .i_start   (r_ex.alu_ctrl == ALU_MUL),
        .i_flush   (i_FlushE),
        .i_a       (w_src_a),
        .i_b       (w_src_b),
        .o_busy    (w_busy),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    always_comb begin
        w_alu = '0;
        case (r_ex.alu_ctrl)
            ALU_ADD:  w_alu = w_src_a + w_src_b;
            ALU_SUB:  w_alu = w_src_a - w_src_b;
            ALU_AND:  w_alu = w_src_a & w_src_b;
            ALU_OR:   w_alu = w_src_a | w_src_b;
            ALU_XOR:  w_alu = w_src_a ^ w_src_b;
            ALU_SLT:  w_alu = {31'd0, $signed(w_src_a) < $signed(w_src_b)};
            ALU_SLTU: w_alu = {31'd0, w_src_a < w_src_b};
            ALU_SLL:  w_alu = w_src_a << w_src_b[4:0];
            ALU_SRL:  w_alu = w_src_a >> w_src_b[4:0];
            ALU_SRA:  w_alu = $signed(w_src_a) >>> w_src_b[4:0];
            ALU_MUL:  w_alu = w_mul_done ? w_product : '0;
            default:  w_alu = '0;
        endcase
    end

    always_comb begin
        w_cond = 1'b0;
        case (r_ex.funct3)
            F3_BEQ:  w_cond = (w_src_a == w_fwd_b);
            F3_BNE:  w_cond = (w_src_a != w_fwd_b);
            F3_BLT:  w_cond = ($signed(w_src_a) < $signed(w_fwd_b));
            F3_BGE:  w_cond = ($signed(w_src_a) >= $signed(w_fwd_b));
            F3_BLTU: w_cond = (w_src_a < w_fwd_b);
            F3_BGEU: w_cond = (w_src_a >= w_fwd_b);
            default: w_cond = 1'b0;
        endcase
    end

    assign o_PCSrcE     = r_ex.jump | (r_ex.branch & w_cond);
    assign o_PCTargetE  = r_ex.jalr ? (w_alu & ~32'd1) : (r_ex.pc + r_ex.imm);
    assign o_BusyE      = w_busy;
    assign o_ALUResultE = w_alu;
    assign o_WriteDataE = w_fwd_b;
    assign o_PCPlus4E   = r_ex.pc_plus4;
    assign o_Rs1E       = r_ex.rs1;
    assign o_Rs2E       = r_ex.rs2;
    assign o_RdE        = r_ex.rd;
    assign o_ResultSrcE = r_ex.result_src;
    assign o_RegWriteE  = r_ex.reg_write & ~w_busy;
    assign o_MemWriteE  = r_ex.mem_write & ~w_busy;

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - scoreboard bench for execute_stage with a reference model
module tb_execute_stage;

    logic        i_Clk;
    logic        i_Reset;
    logic [31:0] i_RD1D, i_RD2D, i_PCD, i_ImmExtD, i_PCPlus4D;
    logic [4:0]  i_Rs1D, i_Rs2D, i_RdD;
    logic        i_RegWriteD, i_MemWriteD, i_JumpD, i_BranchD, i_ALUSrcD, i_JalrD;
    logic [1:0]  i_ResultSrcD;
    logic [3:0]  i_ALUControlD;
    logic [2:0]  i_Funct3D;
    logic        i_FlushE;
    logic [1:0]  i_ForwardAE, i_ForwardBE;
    logic [31:0] i_ALUResultM, i_ResultW;
    logic [4:0]  o_Rs1E, o_Rs2E, o_RdE;
    logic [1:0]  o_ResultSrcE;
    logic        o_PCSrcE, o_BusyE, o_RegWriteE, o_MemWriteE;
    logic [31:0] o_PCTargetE, o_ALUResultE, o_WriteDataE, o_PCPlus4E;

    execute_stage dut (
        .i_Clk(i_Clk), .i_Reset(i_Reset),
        .i_RD1D(i_RD1D), .i_RD2D(i_RD2D), .i_PCD(i_PCD), .i_ImmExtD(i_ImmExtD),
        .i_PCPlus4D(i_PCPlus4D), .i_Rs1D(i_Rs1D), .i_Rs2D(i_Rs2D), .i_RdD(i_RdD),
        .i_RegWriteD(i_RegWriteD), .i_MemWriteD(i_MemWriteD), .i_JumpD(i_JumpD),
        .i_BranchD(i_BranchD), .i_ALUSrcD(i_ALUSrcD), .i_JalrD(i_JalrD),
        .i_ResultSrcD(i_ResultSrcD), .i_ALUControlD(i_ALUControlD), .i_Funct3D(i_Funct3D),
        .i_FlushE(i_FlushE), .i_ForwardAE(i_ForwardAE), .i_ForwardBE(i_ForwardBE),
        .i_ALUResultM(i_ALUResultM), .i_ResultW(i_ResultW),
        .o_Rs1E(o_Rs1E), .o_Rs2E(o_Rs2E), .o_RdE(o_RdE), .o_ResultSrcE(o_ResultSrcE),
        .o_PCSrcE(o_PCSrcE), .o_PCTargetE(o_PCTargetE), .o_BusyE(o_BusyE),
        .o_ALUResultE(o_ALUResultE), .o_WriteDataE(o_WriteDataE), .o_PCPlus4E(o_PCPlus4E),
        .o_RegWriteE(o_RegWriteE), .o_MemWriteE(o_MemWriteE)
    );

    typedef struct {
        logic [31:0] rd1, rd2, pc, imm, pc4;
        logic [4:0]  rs1, rs2, rd;
        logic        rw, mw, jump, branch, alusrc, jalr;
        logic [1:0]  rsrc;
        logic [3:0]  op;
        logic [2:0]  f3;
        logic [1:0]  fa, fb;
        logic [31:0] vm, vw;
    } instr_t;

    typedef struct {
        logic [31:0] alu, wd, tgt, pc4;
        logic [4:0]  rs1, rs2, rd;
        logic [1:0]  rsrc;
        logic        pcsrc, rw, mw;
        int          busy;
    } exp_t;

    exp_t   exp_q[$];
    instr_t prev;
    int     checks = 0;
    int     errors = 0;
    logic   mon_en = 1'b0;

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] r,
                                         input logic [31:0] m, input logic [31:0] w);
        if (s == 2'b01) return w;
        if (s == 2'b10) return m;
        return r;
    endfunction

    // Reference behaviour from the instruction-level rules, not the RTL structure.
    function automatic exp_t model(input instr_t t);
        exp_t        e;
        logic [31:0] a, b, sb, res;
        int          sa, sbs, n;
        logic        cond;
        a   = pick(t.fa, t.rd1, t.vm, t.vw);
        b   = pick(t.fb, t.rd2, t.vm, t.vw);
        sb  = t.alusrc ? t.imm : b;
        sa  = a;
        sbs = sb;
        n   = int'(sb % 32);
        case (t.op)
            4'd0:    res = a + sb;
            4'd1:    res = a - sb;
            4'd2:    res = a & sb;
            4'd3:    res = a | sb;
            4'd4:    res = a ^ sb;
            4'd5:    res = (sa < sbs) ? 32'd1 : 32'd0;
            4'd6:    res = (a < sb) ? 32'd1 : 32'd0;
            4'd7:    res = a * (32'd1 << n);
            4'd8:    res = a / (32'd1 << n);
            4'd9:    res = (a >> n) | (a[31] ? ~(32'hFFFF_FFFF >> n) : 32'd0);
            4'd10:   res = a * sb;
            default: res = 32'd0;
        endcase
        sa  = a;
        sbs = b;
        case (t.f3)
            3'd0:    cond = (a == b);
            3'd1:    cond = (a != b);
            3'd4:    cond = (sa < sbs);
            3'd5:    cond = (sa >= sbs);
            3'd6:    cond = (a < b);
            3'd7:    cond = (a >= b);
            default: cond = 1'b0;
        endcase
        e.alu   = res;
        e.wd    = b;
        e.tgt   = t.jalr ? {res[31:1], 1'b0} : t.pc + t.imm;
        e.pc4   = t.pc4;
        e.rs1   = t.rs1;
        e.rs2   = t.rs2;
        e.rd    = t.rd;
        e.rsrc  = t.rsrc;
        e.pcsrc = t.jump | (t.branch & cond);
        e.rw    = t.rw;
        e.mw    = t.mw;
        e.busy  = (t.op == 4'd10) ? 33 : 0;
        return e;
    endfunction

    function automatic instr_t zero_instr();
        instr_t t;
        t.rd1 = 0; t.rd2 = 0; t.pc = 0; t.imm = 0; t.pc4 = 0;
        t.rs1 = 0; t.rs2 = 0; t.rd = 0;
        t.rw = 0; t.mw = 0; t.jump = 0; t.branch = 0; t.alusrc = 0; t.jalr = 0;
        t.rsrc = 0; t.op = 0; t.f3 = 0; t.fa = 0; t.fb = 0; t.vm = 0; t.vw = 0;
        return t;
    endfunction

    function automatic logic [31:0] rword();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    function automatic instr_t rand_instr();
        instr_t t;
        t.rd1 = rword(); t.rd2 = rword(); t.imm = rword();
        t.pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}; t.pc4 = $urandom;
        t.rs1 = 5'($urandom); t.rs2 = 5'($urandom); t.rd = 5'($urandom);
        t.rw = 1'($urandom); t.mw = 1'($urandom); t.jump = ($urandom_range(0, 7) == 0);
        t.branch = 1'($urandom); t.alusrc = 1'($urandom); t.jalr = 1'($urandom);
        t.rsrc = 2'($urandom); t.op = 4'($urandom); t.f3 = 3'($urandom);
        t.fa = 2'($urandom); t.fb = 2'($urandom); t.vm = rword(); t.vw = rword();
        return t;
    endfunction

    task automatic drive_d(input instr_t t);
        i_RD1D = t.rd1; i_RD2D = t.rd2; i_PCD = t.pc; i_ImmExtD = t.imm; i_PCPlus4D = t.pc4;
        i_Rs1D = t.rs1; i_Rs2D = t.rs2; i_RdD = t.rd;
        i_RegWriteD = t.rw; i_MemWriteD = t.mw; i_JumpD = t.jump; i_BranchD = t.branch;
        i_ALUSrcD = t.alusrc; i_JalrD = t.jalr; i_ResultSrcD = t.rsrc;
        i_ALUControlD = t.op; i_Funct3D = t.f3;
    endtask

    task automatic drive_fwd(input instr_t t);
        i_ForwardAE = t.fa; i_ForwardBE = t.fb; i_ALUResultM = t.vm; i_ResultW = t.vw;
    endtask

    // Present instruction t in D while the previous one sits in E; scramble the
    // forwarding sources during BUSY cycles so captured operands are exercised.
    task automatic issue(input instr_t t);
        int   guard;
        logic was_busy;
        drive_d(t);
        drive_fwd(prev);
        exp_q.push_back(model(t));
        guard = 0;
        forever begin
            was_busy = o_BusyE;
            @(posedge i_Clk);
            #1;
            if (!was_busy) break;
            if (o_BusyE) begin
                i_ALUResultM = $urandom;
                i_ResultW    = $urandom;
            end else begin
                drive_fwd(prev);
            end
            guard++;
            if (guard > 64) begin
                checks++;
                errors++;
                $display("FAIL load_timeout actual=busy expected=released t=%0t", $time);
                break;
            end
        end
        prev   = t;
        mon_en = 1'b1;
    endtask

    initial begin
        exp_t e;
        int   busy_run;
        busy_run = 0;
        forever begin
            @(negedge i_Clk);
            if (mon_en) begin
                if (o_BusyE) begin
                    busy_run++;
                    chk("busy_regwrite", 32'(o_RegWriteE), 32'd0);
                    chk("busy_memwrite", 32'(o_MemWriteE), 32'd0);
                end else if (exp_q.size() == 0) begin
                    chk("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("alu_result", o_ALUResultE, e.alu);
                    chk("write_data", o_WriteDataE, e.wd);
                    chk("pc_target",  o_PCTargetE, e.tgt);
                    chk("pc_src",     32'(o_PCSrcE), 32'(e.pcsrc));
                    chk("pc_plus4",   o_PCPlus4E, e.pc4);
                    chk("regs",       {17'd0, o_Rs1E, o_Rs2E, o_RdE}, {17'd0, e.rs1, e.rs2, e.rd});
                    chk("result_src", 32'(o_ResultSrcE), 32'(e.rsrc));
                    chk("reg_write",  32'(o_RegWriteE), 32'(e.rw));
                    chk("mem_write",  32'(o_MemWriteE), 32'(e.mw));
                    chk("busy_cycles", 32'(busy_run), 32'(e.busy));
                    busy_run = 0;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"},    32'(o_BusyE), 32'd0);
        chk({tag, "_pcsrc"},   32'(o_PCSrcE), 32'd0);
        chk({tag, "_regwr"},   32'(o_RegWriteE), 32'd0);
        chk({tag, "_memwr"},   32'(o_MemWriteE), 32'd0);
        chk({tag, "_alu"},     o_ALUResultE, 32'd0);
        chk({tag, "_wdata"},   o_WriteDataE, 32'd0);
        chk({tag, "_target"},  o_PCTargetE, 32'd0);
        chk({tag, "_pc4"},     o_PCPlus4E, 32'd0);
        chk({tag, "_rd"},      32'(o_RdE), 32'd0);
    endtask

    initial begin
        instr_t t;
        prev = zero_instr();
        i_Reset = 1'b0;
        i_FlushE = 1'b0;
        drive_d(zero_instr());
        drive_fwd(zero_instr());
        repeat (3) @(posedge i_Clk);
        #1;
        check_idle_outputs("reset");
        i_Reset = 1'b1;

        t = zero_instr();
        t.rd1 = 32'd5; t.rd2 = 32'd7; t.rd = 5'd3; t.rw = 1'b1;
        t.fa = 2'b10; t.vm = 32'd100;
        issue(t);

        t = zero_instr();
        t.rd1 = 32'hFFFF_FFFF; t.rd2 = 32'd1; t.branch = 1'b1; t.f3 = 3'b100;
        t.pc = 32'h0000_0100; t.imm = 32'h0000_0040; t.op = 4'd1;
        issue(t);
        t.f3 = 3'b110;
        issue(t);

        t = zero_instr();
        t.rd1 = 32'hFFFF_FFFF; t.imm = 32'd3; t.alusrc = 1'b1; t.op = 4'd10;
        t.rw = 1'b1; t.rd = 5'd7;
        issue(t);

        t = zero_instr();
        t.fa = 2'b01; t.vw = 32'h0000_1234; t.rd2 = 32'h0000_0055; t.op = 4'd10;
        t.rw = 1'b1; t.rd = 5'd8;
        issue(t);

        t = zero_instr();
        t.jump = 1'b1; t.jalr = 1'b1; t.rd1 = 32'h0000_1001; t.imm = 32'd4;
        t.alusrc = 1'b1; t.rw = 1'b1; t.rd = 5'd1;
        issue(t);

        for (int i = 0; i < 150; i++) issue(rand_instr());

        drive_d(zero_instr());
        drive_fwd(prev);
        for (int n = 0; n < 60 && exp_q.size() != 0; n++) begin
            @(negedge i_Clk);
            #1;
        end
        mon_en = 1'b0;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        @(posedge i_Clk);
        #1;
        drive_fwd(zero_instr());
        t = zero_instr();
        t.rd1 = 32'd9; t.rd2 = 32'd11; t.op = 4'd10; t.rw = 1'b1; t.rd = 5'd4;
        drive_d(t);
        @(posedge i_Clk);
        #1;
        drive_d(zero_instr());
        repeat (11) @(posedge i_Clk);
        #2;
        chk("mid_mul_busy", 32'(o_BusyE), 32'd1);
        i_Reset = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        @(posedge i_Clk);
        #1;
        i_Reset = 1'b1;

        t.mw = 1'b1; t.rd = 5'd9;
        drive_d(t);
        @(posedge i_Clk);
        #1;
        drive_d(zero_instr());
        repeat (5) @(posedge i_Clk);
        #1;
        chk("flush_pre_busy", 32'(o_BusyE), 32'd1);
        i_FlushE = 1'b1;
        @(posedge i_Clk);
        #1;
        i_FlushE = 1'b0;
        check_idle_outputs("flush");
        @(posedge i_Clk);
        #1;
        chk("flush_after_busy", 32'(o_BusyE), 32'd0);
        chk("flush_after_regwr", 32'(o_RegWriteE), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
